// File: rtl/l1_threshold_servo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l1_threshold_servo_pkg
// Purpose  : Shared L1 trigger definitions: servo FSM state encoding, default
//            L1 register-map addresses and a beam address helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package l1_threshold_servo_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle    = 3'd0;
    localparam state_t c_st_rd_cnt  = 3'd1;
    localparam state_t c_st_rd_thr  = 3'd2;
    localparam state_t c_st_calc    = 3'd3;
    localparam state_t c_st_wr_thr  = 3'd4;
    localparam state_t c_st_next    = 3'd5;
    localparam state_t c_st_wr_ctrl = 3'd6;

    localparam logic [12:0] c_thr_base   = 13'h0800;
    localparam logic [12:0] c_cnt_base   = 13'h0C00;
    localparam logic [12:0] c_ctrl_addr  = 13'h1800;
    localparam logic [31:0] c_update_val = 32'h0000_0002;

    // Per-beam registers are word spaced: base + 4*beam.
    function automatic logic [12:0] beam_addr(input logic [12:0] base,
                                              input logic [5:0]  beam);
        return base + {5'b0, beam, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/l1_threshold_servo_step.sv
`default_nettype none
// ============================================================================
// Module   : l1_servo_step
// Purpose  : Combinational threshold update for one beam. Raises the
//            threshold when the count is above the deadband, lowers it when
//            below, with saturating bounds and clamped results.
// Ports    : i_count, i_target, i_tol (32b), i_thr, i_step (18b) -> o_new_thr
// Revision : 1.0 - initial release
// ============================================================================
module l1_servo_step #(
    parameter logic [17:0] THR_MIN = 18'd0,
    parameter logic [17:0] THR_MAX = 18'h3FFFF
) (
    input  logic [31:0] i_count,
    input  logic [31:0] i_target,
    input  logic [31:0] i_tol,
    input  logic [17:0] i_thr,
    input  logic [17:0] i_step,
    output logic [17:0] o_new_thr
);

    logic [32:0] w_hi_raw;
    logic [32:0] w_lo_raw;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic [18:0] w_up;
    logic [18:0] w_dn;
    logic [17:0] w_up_clamp;
    logic [17:0] w_dn_clamp;

    always_comb begin
        // Deadband edges in 33 bits; the carry/borrow bit selects saturation.
        w_hi_raw = {1'b0, i_target} + {1'b0, i_tol};
        w_lo_raw = {1'b0, i_target} - {1'b0, i_tol};
        w_hi     = w_hi_raw[32] ? 32'hFFFF_FFFF : w_hi_raw[31:0];
        w_lo     = w_lo_raw[32] ? 32'd0         : w_lo_raw[31:0];

        // Step in 19 bits so an overflow or underflow is visible before clamping.
        w_up       = {1'b0, i_thr} + {1'b0, i_step};
        w_dn       = {1'b0, i_thr} - {1'b0, i_step};
        w_up_clamp = (w_up > {1'b0, THR_MAX}) ? THR_MAX : w_up[17:0];
        w_dn_clamp = (w_dn[18] || (w_dn[17:0] < THR_MIN)) ? THR_MIN : w_dn[17:0];

        if (i_count > w_hi) begin
            o_new_thr = w_up_clamp;
        end else if (i_count < w_lo) begin
            o_new_thr = w_dn_clamp;
        end else begin
            o_new_thr = i_thr;
        end
    end

endmodule
`default_nettype wire

// File: rtl/l1_threshold_servo.sv
`default_nettype none
// ============================================================================
// Module   : l1_threshold_servo
// Purpose  : Wishbone master that sweeps all beams after each count-done
//            pulse, reads count and threshold, nudges the threshold toward
//            the target rate and commits changes with a control write.
// Ports    : wb_clk_i, wb_rstn_i         - clock, async active-low reset
//            wb_cyc/stb/we/adr/dat/sel_o - Wishbone master request
//            wb_ack_i, wb_dat_i          - Wishbone response
//            trigger_count_done_i        - new counts valid (1-cycle pulse)
//            servo_en_i, target_i, tol_i, step_i - servo control
//            busy_o, overrun_o, beam_o   - status
// Revision : 1.0 - initial release
// ============================================================================
module l1_threshold_servo
    import l1_threshold_servo_pkg::*;
#(
    parameter int          NBEAMS     = 46,
    parameter logic [12:0] THR_BASE   = c_thr_base,
    parameter logic [12:0] CNT_BASE   = c_cnt_base,
    parameter logic [12:0] CTRL_ADDR  = c_ctrl_addr,
    parameter logic [31:0] UPDATE_VAL = c_update_val,
    parameter logic [17:0] THR_MIN    = 18'd0,
    parameter logic [17:0] THR_MAX    = 18'h3FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [12:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    input  logic        trigger_count_done_i,
    input  logic        servo_en_i,
    input  logic [31:0] target_i,
    input  logic [31:0] tol_i,
    input  logic [17:0] step_i,
    output logic        busy_o,
    output logic        overrun_o,
    output logic [5:0]  beam_o
);

    localparam logic [5:0] c_last_beam = 6'(NBEAMS - 1);

    state_t      r_state, w_state_next;
    logic [5:0]  r_beam,  w_beam_next;
    logic [31:0] r_count;
    logic [17:0] r_thr;
    logic [17:0] w_new_thr;
    logic        r_changed, r_pending, r_overrun;

    logic        r_cyc,  w_cyc_next;
    logic        r_we,   w_we_next;
    logic [12:0] r_adr,  w_adr_next;
    logic [31:0] r_dat,  w_dat_next;
    logic [3:0]  r_sel,  w_sel_next;

    // An ack only counts while a request is outstanding; stale acks are dropped.
    logic w_ack, w_start;
    assign w_ack   = r_cyc & wb_ack_i;
    assign w_start = servo_en_i & (trigger_count_done_i | r_pending);

    l1_servo_step #(
        .THR_MIN (THR_MIN),
        .THR_MAX (THR_MAX)
    ) u_step (
        .i_count   (r_count),
        .i_target  (target_i),
        .i_tol     (tol_i),
        .i_thr     (r_thr),
        .i_step    (step_i),
        .o_new_thr (w_new_thr)
    );

    // State register
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_state <= c_st_idle;
            r_beam  <= '0;
        end else begin
            r_state <= w_state_next;
            r_beam  <= w_beam_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_beam_next  = r_beam;
        case (r_state)
            c_st_idle: begin
                if (w_start) begin
                    w_state_next = c_st_rd_cnt;
                    w_beam_next  = '0;
                end
            end
            c_st_rd_cnt:  if (w_ack) w_state_next = c_st_rd_thr;
            c_st_rd_thr:  if (w_ack) w_state_next = c_st_calc;
            c_st_calc:    w_state_next = (w_new_thr != r_thr) ? c_st_wr_thr : c_st_next;
            c_st_wr_thr:  if (w_ack) w_state_next = c_st_next;
            c_st_next: begin
                if (!servo_en_i) begin
                    w_state_next = c_st_idle;
                end else if (r_beam == c_last_beam) begin
                    w_state_next = r_changed ? c_st_wr_ctrl : c_st_idle;
                end else begin
                    w_state_next = c_st_rd_cnt;
                    w_beam_next  = r_beam + 6'd1;
                end
            end
            c_st_wr_ctrl: if (w_ack) w_state_next = c_st_idle;
            default:      w_state_next = c_st_idle;
        endcase
    end

    // Output logic: bus request for the state being entered. The request drops
    // in the cycle after an ack, so back-to-back reads get a one-cycle gap.
    always_comb begin
        w_cyc_next = 1'b0;
        w_we_next  = 1'b0;
        w_adr_next = '0;
        w_dat_next = '0;
        w_sel_next = 4'h0;
        case (w_state_next)
            c_st_rd_cnt: begin
                w_cyc_next = ~w_ack;
                w_adr_next = beam_addr(CNT_BASE, w_beam_next);
            end
            c_st_rd_thr: begin
                w_cyc_next = ~w_ack;
                w_adr_next = beam_addr(THR_BASE, w_beam_next);
            end
            c_st_wr_thr: begin
                w_cyc_next = ~w_ack;
                w_we_next  = 1'b1;
                w_adr_next = beam_addr(THR_BASE, w_beam_next);
                w_dat_next = {14'b0, w_new_thr};
                w_sel_next = 4'hF;
            end
            c_st_wr_ctrl: begin
                w_cyc_next = ~w_ack;
                w_we_next  = 1'b1;
                w_adr_next = CTRL_ADDR;
                w_dat_next = UPDATE_VAL;
                w_sel_next = 4'hF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= 4'h0;
        end else begin
            r_cyc <= w_cyc_next;
            r_we  <= w_we_next;
            r_adr <= w_adr_next;
            r_dat <= w_dat_next;
            r_sel <= w_sel_next;
        end
    end

    // Datapath captures and sweep bookkeeping
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_count   <= '0;
            r_thr     <= '0;
            r_changed <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == c_st_rd_cnt && w_ack) r_count <= wb_dat_i;
            if (r_state == c_st_rd_thr && w_ack) r_thr   <= wb_dat_i[17:0];

            if (r_state == c_st_idle && w_start) begin
                r_changed <= 1'b0;
            end else if (r_state == c_st_wr_thr && w_ack) begin
                r_changed <= 1'b1;
            end

            // A pulse while sweeping is remembered once; a second one is an overrun.
            if (r_state == c_st_idle) begin
                if (w_start) r_pending <= 1'b0;
            end else if (trigger_count_done_i) begin
                r_pending <= 1'b1;
                if (r_pending) r_overrun <= 1'b1;
            end
        end
    end

    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_cyc;
    assign wb_we_o   = r_we;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = r_sel;
    assign busy_o    = (r_state != c_st_idle);
    assign overrun_o = r_overrun;
    assign beam_o    = r_beam;

endmodule
`default_nettype wire
